// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel position from a VGA-style sync/RGB stream, tracks timing
//   lock, and measures per-bin bar heights from the recovered picture.
//
//   Ports
//     vgaclk         pixel clock, all logic on its rising edge
//     rst            synchronous reset, active-high
//     hsync, vsync   active-low sync inputs
//     red/green/blue 4-bit pixel colour inputs
//     x, y           recovered position of the registered pixel (rgb_q)
//     active         x<HACT && y<VACT while locked
//     locked         timing lock indicator
//     timing_err     one-cycle pulse on a sync timing violation
//     heights        16 x 9-bit bar height per bin
//     heights_valid  one-cycle pulse when heights is refreshed
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   UNLOCKED | counters resync to every sync falling edge, no checking
//   ACQUIRE  | counters free-run and are checked; waiting for a clean vsync
//   LOCKED   | counters free-run and are checked; outputs are trusted

module vga_sync_decoder #(
   parameter int HTOTAL      = 800,
   parameter int VTOTAL      = 525,
   parameter int HSYNC_START = 656,
   parameter int HSYNC_LEN   = 96,
   parameter int VSYNC_START = 490,
   parameter int VSYNC_LEN   = 2,
   parameter int HACT        = 640,
   parameter int VACT        = 480,
   parameter int BIN_W       = 40
) (
   input  logic             vgaclk,
   input  logic             rst,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [3:0]       red,
   input  logic [3:0]       green,
   input  logic [3:0]       blue,
   output logic [9:0]       x,
   output logic [9:0]       y,
   output logic             active,
   output logic             locked,
   output logic             timing_err,
   output logic [15:0][8:0] heights,
   output logic             heights_valid
);

   localparam logic [9:0] H_MAX    = 10'(HTOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(VTOTAL - 1);
   localparam logic [9:0] H_FALL   = 10'(HSYNC_START);
   localparam logic [9:0] H_RESYNC = 10'(HSYNC_START + 1);
   localparam logic [9:0] H_RISE   = 10'(HSYNC_START + HSYNC_LEN);
   localparam logic [9:0] V_FALL   = 10'(VSYNC_START);
   localparam logic [9:0] V_RISE   = 10'(VSYNC_START + VSYNC_LEN);
   localparam logic [9:0] H_ACT    = 10'(HACT);
   localparam logic [9:0] V_ACT    = 10'(VACT);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t           state;
   logic             hs_q;
   logic             vs_q;
   logic [11:0]      rgb_q;
   logic [9:0]       h;
   logic [9:0]       v;
   logic [9:0]       h_inc;
   logic [9:0]       v_inc;
   logic             hs_fall;
   logic             hs_rise;
   logic             vs_fall;
   logic             vs_rise;
   logic             at_hfall;
   logic             at_hrise;
   logic             at_vfall;
   logic             at_vrise;
   logic             checking;
   logic             violation;
   logic             resync;
   logic             lock_nxt;
   logic             frame_ok;
   logic             frame_end;
   logic [15:0][8:0] acc;

   assign hs_fall = hs_q & ~hsync;
   assign hs_rise = ~hs_q & hsync;
   assign vs_fall = vs_q & ~vsync;
   assign vs_rise = ~vs_q & vsync;

   // Vertical sync edges are expected to coincide with the hsync falling edge.
   assign at_hfall = (h == H_FALL);
   assign at_hrise = (h == H_RISE);
   assign at_vfall = at_hfall && (v == V_FALL);
   assign at_vrise = at_hfall && (v == V_RISE);

   // Either an edge in the wrong place or an expected edge that never came.
   assign violation = (hs_fall != at_hfall) || (hs_rise != at_hrise) ||
                      (vs_fall != at_vfall) || (vs_rise != at_vrise);

   assign checking = (state != UNLOCKED);
   assign resync   = !checking || violation;

   // Lock status as it will be after this edge, so that locked/active/x/y
   // all refer to the same pixel.
   assign lock_nxt = !violation &&
                     ((state == LOCKED) || ((state == ACQUIRE) && vs_fall));

   assign h_inc = (h == H_MAX) ? '0 : h + 10'd1;
   assign v_inc = (h != H_MAX) ? v : ((v == V_MAX) ? '0 : v + 10'd1);

   always_ff @(posedge vgaclk) begin
      if (rst) begin
         state      <= UNLOCKED;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         rgb_q      <= '0;
         h          <= '0;
         v          <= '0;
         x          <= '0;
         y          <= '0;
         active     <= 1'b0;
         locked     <= 1'b0;
         timing_err <= 1'b0;
      end else begin
         hs_q       <= hsync;
         vs_q       <= vsync;
         rgb_q      <= {red, green, blue};
         x          <= h;
         y          <= v;
         active     <= (h < H_ACT) && (v < V_ACT) && lock_nxt;
         locked     <= lock_nxt;
         timing_err <= checking && violation;

         // The sample carrying the falling edge is HSYNC_START, so the next
         // pixel is HSYNC_START+1.
         if (resync && hs_fall) begin
            h <= H_RESYNC;
         end else begin
            h <= h_inc;
         end

         if (resync && vs_fall) begin
            v <= V_FALL;
         end else if (resync && hs_fall) begin
            v <= v;
         end else begin
            v <= v_inc;
         end

         case (state)
            UNLOCKED: begin
               if (vs_fall) begin
                  state <= ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (violation) begin
                  state <= UNLOCKED;
               end else if (vs_fall) begin
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (violation) begin
                  state <= UNLOCKED;
               end
            end
            default: state <= UNLOCKED;
         endcase
      end
   end

   // Frame boundaries are decided on the counters so heights_valid lines up
   // with the cycle whose x/y outputs show (0, VACT).
   assign frame_end = lock_nxt && frame_ok && (h == '0) && (v == V_ACT);

   always_ff @(posedge vgaclk) begin
      if (rst) begin
         acc           <= '0;
         heights       <= '0;
         heights_valid <= 1'b0;
         frame_ok      <= 1'b0;
      end else begin
         if ((x == '0) && (y == '0)) begin
            acc <= '0;
         end else if (active && (rgb_q != 12'd0)) begin
            for (int b = 0; b < 16; b++) begin
               if ((x == 10'(BIN_W * b + BIN_W / 2)) && (acc[b] != 9'h1ff)) begin
                  acc[b] <= acc[b] + 9'd1;
               end
            end
         end

         // frame_ok: lock has held continuously since the last frame start.
         if (!lock_nxt) begin
            frame_ok <= 1'b0;
         end else if ((h == '0) && (v == '0)) begin
            frame_ok <= 1'b1;
         end

         heights_valid <= frame_end;
         if (frame_end) begin
            heights <= acc;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Drives a scaled-down VGA source (48x56 total, 32x48 active, 2-pixel bins)
//   into vga_sync_decoder and compares every cycle against a reference model
//   of lock status, position recovery and bar heights.

module tb_vga_sync_decoder;

   localparam int HT    = 48;
   localparam int VT    = 56;
   localparam int HS    = 36;
   localparam int HL    = 6;
   localparam int VS    = 50;
   localparam int VL    = 2;
   localparam int HA    = 32;
   localparam int VA    = 48;
   localparam int BW    = 2;
   localparam int BLACK = 3;   // rows of bin 0 the source always paints black
   localparam int FRAME = HT * VT;
   localparam int BIG   = 32'h7fffffff;

   logic             vgaclk = 1'b0;
   logic             rst;
   logic             hsync;
   logic             vsync;
   logic [3:0]       red;
   logic [3:0]       green;
   logic [3:0]       blue;
   logic [9:0]       x;
   logic [9:0]       y;
   logic             active;
   logic             locked;
   logic             timing_err;
   logic [15:0][8:0] heights;
   logic             heights_valid;

   int vectors     = 0;
   int miscompares = 0;

   // source state
   int hc, vc;
   int bar [16];
   int nbar [16];
   bit noise, nnoise;
   bit vs_prev;
   int gkind;                 // 0 none, 1 hsync one pixel late, 2 hsync one pixel short
   int gline;

   // sample now on the pins
   int s_hc, s_vc;
   bit s_vfall, s_viol, s_rst;

   // reference model
   int               cyc;
   bit               exp_locked, exp_terr, exp_hv;
   int               nfall, lock_since, frame_start;
   logic [15:0][8:0] exp_heights;

   vga_sync_decoder #(
      .HTOTAL(HT), .VTOTAL(VT), .HSYNC_START(HS), .HSYNC_LEN(HL),
      .VSYNC_START(VS), .VSYNC_LEN(VL), .HACT(HA), .VACT(VA), .BIN_W(BW)
   ) dut (
      .vgaclk        (vgaclk),
      .rst           (rst),
      .hsync         (hsync),
      .vsync         (vsync),
      .red           (red),
      .green         (green),
      .blue          (blue),
      .x             (x),
      .y             (y),
      .active        (active),
      .locked        (locked),
      .timing_err    (timing_err),
      .heights       (heights),
      .heights_valid (heights_valid)
   );

   always #5 vgaclk = ~vgaclk;

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Height seen for a bar of n lit rows, minus the black overlay in bin 0.
   function automatic logic [15:0][8:0] calc_heights();
      logic [15:0][8:0] r;
      int n;
      for (int b = 0; b < 16; b++) begin
         n = bar[b];
         if (b == 0 && n > VA - BLACK) n = VA - BLACK;
         r[b] = 9'(n);
      end
      return r;
   endfunction

   task automatic drive();
      int st, len, p, c, bi;
      bit vlo, glitch, lit;
      if (hc == 0 && vc == 0) begin
         bar   = nbar;
         noise = nnoise;
      end
      glitch = (gkind != 0) && (vc == gline);
      st  = (glitch && gkind == 1) ? HS + 1 : HS;
      len = (glitch && gkind == 2) ? HL - 1 : HL;
      hsync = !(hc >= st && hc < st + len);
      p   = vc * HT + hc;
      vlo = (p >= VS * HT + HS) && (p < (VS + VL) * HT + HS);
      vsync   = !vlo;
      s_vfall = vlo && vs_prev;
      vs_prev = !vlo;
      s_viol  = glitch && ((gkind == 1) ? (hc == HS) : (hc == HS + HL - 1));
      if (hc < HA && vc < VA && (hc % BW) == BW / 2) begin
         bi  = hc / BW;
         lit = (vc >= VA - bar[bi]) && !(bi == 0 && vc < BLACK);
         c   = lit ? int'($urandom_range(4095, 1)) : 0;
      end else begin
         c = noise ? int'($urandom_range(4095, 0)) : 0;
      end
      {red, green, blue} = 12'(c);
      s_hc = hc;
      s_vc = vc;
      if (glitch && hc == HT - 1) gkind = 0;
      if (hc == HT - 1) begin
         hc = 0;
         vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
         hc++;
      end
   endtask

   task automatic step();
      s_rst = rst;
      @(posedge vgaclk);
      #1;
      cyc++;
      exp_terr = 1'b0;
      exp_hv   = 1'b0;
      if (s_rst) begin
         exp_locked  = 1'b0;
         nfall       = 0;
         lock_since  = BIG;
         exp_heights = '0;
      end else begin
         if (s_viol) begin
            exp_terr   = 1'b1;
            exp_locked = 1'b0;
            nfall      = 0;
            lock_since = BIG;
         end else if (s_vfall) begin
            nfall++;
            if (nfall == 2) begin
               exp_locked = 1'b1;
               lock_since = cyc;
            end
         end
         if (s_hc == 0 && s_vc == 0) frame_start = cyc;
         if (exp_locked && s_hc == 0 && s_vc == VA && lock_since <= frame_start) begin
            exp_hv      = 1'b1;
            exp_heights = calc_heights();
         end
      end
      chk("locked", 144'(locked), 144'(exp_locked));
      chk("timing_err", 144'(timing_err), 144'(exp_terr));
      chk("heights_valid", 144'(heights_valid), 144'(exp_hv));
      chk("heights", 144'(heights), 144'(exp_heights));
      if (exp_locked) begin
         chk("x", 144'(x), 144'(s_hc));
         chk("y", 144'(y), 144'(s_vc));
         chk("active", 144'(active), 144'(s_hc < HA && s_vc < VA));
      end else begin
         chk("active_unlocked", 144'(active), 144'(0));
      end
      if (s_rst) begin
         chk("x_rst", 144'(x), 144'(0));
         chk("y_rst", 144'(y), 144'(0));
      end
      drive();
   endtask

   task automatic wait_hv(input string tag);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 5 * FRAME) begin
         step();
         n++;
         if (heights_valid === 1'b1) got = 1'b1;
      end
      chk(tag, 144'(got), 144'(1));
   endtask

   task automatic wait_terr(input string tag, output int xat);
      int n = 0;
      bit got = 1'b0;
      xat = -1;
      while (!got && n < 3 * FRAME) begin
         step();
         n++;
         if (timing_err === 1'b1) begin
            got = 1'b1;
            xat = int'(x);
         end
      end
      chk(tag, 144'(got), 144'(1));
   endtask

   initial begin
      int xat, n;
      hc = 0; vc = 0; vs_prev = 1'b1; gkind = 0; gline = 10;
      noise = 1'b0; nnoise = 1'b0;
      cyc = 0; exp_locked = 1'b0; exp_terr = 1'b0; exp_hv = 1'b0;
      nfall = 0; lock_since = BIG; frame_start = -1; exp_heights = '0;
      for (int b = 0; b < 16; b++) begin
         bar[b]  = 0;
         nbar[b] = (b == 5) ? 8 : 0;   // bin 5 lit in the bottom 8 rows
      end
      rst = 1'b1;
      drive();
      repeat (4) step();
      rst = 1'b0;

      // lock from reset and single-bar frame
      wait_hv("hv_bin5");

      // every bin at full height
      for (int b = 0; b < 16; b++) nbar[b] = VA;
      wait_hv("hv_full");

      // random bars with noise off the sample columns
      nnoise = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < 16; b++) nbar[b] = int'($urandom_range(VA, 0));
         wait_hv("hv_random");
      end

      // hsync one pixel late on one line
      gkind = 1;
      wait_terr("terr_late", xat);
      chk("x_at_late_err", 144'(xat), 144'(HS));
      chk("locked_after_late", 144'(locked), 144'(0));
      wait_hv("hv_relock_late");

      // hsync one pixel short on one line
      gkind = 2;
      wait_terr("terr_short", xat);
      chk("x_at_short_err", 144'(xat), 144'(HS + HL - 1));
      chk("locked_after_short", 144'(locked), 144'(0));
      wait_hv("hv_relock_short");

      // reset mid-frame while locked
      n = 0;
      while (!(s_vc == 10 && s_hc == 5) && n < 2 * FRAME) begin
         step();
         n++;
      end
      chk("locked_before_rst", 144'(locked), 144'(1));
      rst = 1'b1;
      step();
      chk("heights_rst", 144'(heights), 144'(0));
      step();
      rst = 1'b0;
      wait_hv("hv_relock_rst");
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters: HTOTAL=800, line length in pixels; VTOTAL=525, frame length in lines; HSYNC_START=656, HSYNC_LEN=96, VSYNC_START=490, VSYNC_LEN=2, sync placement; HACT=640, VACT=480, active area; BIN_W=40, bar-bin width.
REQ-002 SHALL have ports:
  vgaclk  in  1  pixel clock; one clock domain, all logic on its rising edge.
  rst  in  1  synchronous reset, active-high.
  hsync  in  1  horizontal sync, active-low.
  vsync  in  1  vertical sync, active-low.
  red  in  4  pixel red.
  green  in  4  pixel green.
  blue  in  4  pixel blue.
  x  out  10  recovered horizontal position.
  y  out  10  recovered vertical position.
  active  out  1  x<HACT && y<VACT, and locked.
  locked  out  1  timing lock indicator.
  timing_err  out  1  one-cycle pulse on timing violation.
  heights  out  9 x 16  recovered bar height per bin.
  heights_valid  out  1  one-cycle pulse when heights updates.

Function
REQ-003 SHALL register hsync, vsync and RGB once (hs_q, vs_q, rgb_q); falling edge = hsync==0 && hs_q==1 (same for vsync).
REQ-004 SHALL keep counters h (0..HTOTAL-1) and v (0..VTOTAL-1); h wraps to 0 and increments v; v wraps to 0 after VTOTAL-1.
REQ-005 Alignment: the input sample showing the hsync falling edge corresponds to h=HSYNC_START, so h SHALL equal HSYNC_START+1 on the following cycle; x/y/active SHALL be outputs of registers so x,y describe rgb_q (1-cycle latency from pins).
REQ-006 FSM states SHALL be UNLOCKED, ACQUIRE, LOCKED.
REQ-007 UNLOCKED: every hsync falling edge forces h to HSYNC_START+1; every vsync falling edge forces v to VSYNC_START (at an h-resync on the same cycle, v SHALL take VSYNC_START) and SHALL move to ACQUIRE.
REQ-008 ACQUIRE/LOCKED: counters free-run; checks active: hsync falling edge only when h==HSYNC_START; hsync rising edge only when h==HSYNC_START+HSYNC_LEN; vsync falling edge only at v==VSYNC_START && h==HSYNC_START; vsync rising edge only at v==VSYNC_START+VSYNC_LEN && h==HSYNC_START; missing expected edge is also a violation.
REQ-009 ACQUIRE -> LOCKED on the next vsync falling edge with zero violations since entry.
REQ-010 Any violation in ACQUIRE or LOCKED SHALL pulse timing_err for exactly one cycle, go to UNLOCKED, and apply REQ-007 resync on that same edge if it is a falling edge.
REQ-011 locked SHALL be 1 only in LOCKED; active SHALL be 0 unless locked.
REQ-012 Bin sampling: for b=0..15, a sample is taken when active and x==BIN_W*b+BIN_W/2 (20, 60, ... 620); lit = rgb_q != 0.
REQ-013 Per-bin accumulator (9 bits) SHALL increment on each lit sample, saturating at 511; all accumulators clear when y==0 && x==0.
REQ-014 At y==VACT && x==0: if LOCKED for the entire frame (since the previous y==0,x==0), copy accumulators to heights and pulse heights_valid one cycle; otherwise hold heights, no pulse.
REQ-015 Lost lock mid-frame SHALL suppress that frame's heights_valid; heights hold the last valid frame.
REQ-016 Lit pixels of bin 0 in rows 0..29 are black by construction of the source and are not counted; heights[0] reads accordingly (accepted behaviour).

Reset
REQ-017 On rst: state UNLOCKED, h=0, v=0, x=0, y=0, hs_q=vs_q=1, rgb_q=0, active=0, locked=0, timing_err=0, heights all 0, heights_valid=0, accumulators 0.
REQ-018 rst asserted mid-frame SHALL take effect the next edge; no timing_err or heights_valid is produced by reset.

Verification
REQ-019 Bench SHALL cover:
  - Drive a standard 800x525 source from reset -> locked=1 at the second vsync falling edge; x==hc(t-1), y==vc(t-1) thereafter; no timing_err.
  - Source bars all 0 except bin 5 lit rows 400..479 -> heights[5]=80, others 0, heights_valid pulse at y=480,x=0.
  - All bins lit full height, bins 1..15 -> heights[b]=480 (b>=1); heights[0]=450.
  - Once locked, shift one hsync pulse 1 pixel late -> timing_err one-cycle pulse, locked=0, relock after two vsync edges; that frame has no heights_valid.
  - Hsync pulse 95 wide -> timing_err at h=751 position, state UNLOCKED.
  - rst asserted mid-frame while locked -> all outputs at reset values next cycle; relock follows.
